ps2_key_sequencer: RTL

//  Controller between the ps2_keyboard receiver FIFO and the display/counter logic.
//  - Pops scan-code bytes from the receiver with the ready/nextdata_n handshake.
//  - Folds E0 (extended) and F0 (break) prefixes into single key events.
//  - Tracks the held key, suppresses typematic repeats and counts distinct key presses.

---
 rtl/ps2_key_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer: pops scan-code bytes from the PS/2 receiver FIFO, folds E0/F0
// prefixes into single key events, tracks the held key and counts distinct presses.
// Optional feature macro: PS2_SEQ_REPEAT_EN (typematic repeats also pulse key_valid).
module ps2_key_sequencer #(
    parameter int unsigned COUNT_W        = 8,
    parameter int unsigned PREFIX_TIMEOUT = 2000000,
    parameter int unsigned TMO_W          = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ready,
    input  logic [7:0]         data,
    input  logic               overflow,
    output logic               nextdata_n,
    output logic               key_valid,
    output logic [7:0]         key_code,
    output logic               key_ext,
    output logic               key_down,
    output logic [COUNT_W-1:0] key_count,
    output logic               ovf_sticky
);

    typedef enum logic [1:0] {StIdle, StPop, StGap, StProc} state_t;

    localparam logic [TMO_W-1:0] TmoLast = TMO_W'(PREFIX_TIMEOUT - 1);

    state_t           state;
    logic [7:0]       byte_r;
    logic             ext_pend;
    logic             brk_pend;
    logic [7:0]       held_code;
    logic             held_ext;
    logic [TMO_W-1:0] tmo_cnt;
    logic             match;

    // Current byte (with pending E0) names the key we are tracking.
    assign match = (byte_r == held_code) && (ext_pend == held_ext);

    // Pop strobe is a pure state decode so a reset in POP releases it immediately.
    assign nextdata_n = (state != StPop);

    // Byte handshake FSM, prefix decode, held-key tracking and prefix timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            byte_r     <= 8'h00;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            held_code  <= 8'h00;
            held_ext   <= 1'b0;
            tmo_cnt    <= '0;
            key_valid  <= 1'b0;
            key_code   <= 8'h00;
            key_ext    <= 1'b0;
            key_down   <= 1'b0;
            key_count  <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (overflow) begin
                ovf_sticky <= 1'b1;
            end
            case (state)
                StIdle: begin
                    if (ready) begin
                        byte_r <= data;
                        state  <= StPop;
                    end else if (ext_pend || brk_pend) begin
                        // A lone prefix with no follow-up byte is discarded.
                        if (tmo_cnt == TmoLast) begin
                            ext_pend <= 1'b0;
                            brk_pend <= 1'b0;
                            tmo_cnt  <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                end
                StPop: begin
                    tmo_cnt <= '0;
                    state   <= StGap;
                end
                StGap: begin
                    state <= StProc;
                end
                StProc: begin
                    state <= StIdle;
                    if (byte_r == 8'hE0) begin
                        ext_pend <= 1'b1;
                    end else if (byte_r == 8'hF0) begin
                        brk_pend <= 1'b1;
                    end else begin
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                        if (brk_pend) begin
                            // Breaks for keys other than the held one are ignored.
                            if (match) begin
                                key_down <= 1'b0;
                            end
                        end else if (key_down && match) begin
`ifdef PS2_SEQ_REPEAT_EN
                            key_valid <= 1'b1;
`else
                            key_valid <= 1'b0;
`endif
                        end else begin
                            key_valid <= 1'b1;
                            key_code  <= byte_r;
                            key_ext   <= ext_pend;
                            held_code <= byte_r;
                            held_ext  <= ext_pend;
                            key_down  <= 1'b1;
                            key_count <= key_count + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
